// File: rtl/lcd_frame_capture.sv
// Captures the PPU 2-bit pixel stream into a byte-wide framebuffer, four pixels per byte.
// Optional palette mapping of each pixel before packing: define LCD_CAPTURE_PALETTE_EN.
module lcd_frame_capture #(
    parameter int LINE_WIDTH = 160,
    parameter int LINES      = 144,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              pix_valid,
    input  logic [1:0]        pix_data,
    input  logic [7:0]        pal_raw,
    input  logic              err_clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [7:0]        cur_line,
    output logic [7:0]        cur_col,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              err_overflow,
    output logic              err_short_line,
    output logic              err_short_frame
);

    // Stream handshake: a pixel transfers on any cycle with pix_valid high. There is no
    // ready; pixels offered outside an active line are dropped and flagged as overflow.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    localparam logic [7:0]        LAST_COL       = 8'(LINE_WIDTH - 1);
    localparam logic [7:0]        LAST_LINE      = 8'(LINES - 1);
    localparam logic [ADDR_W-1:0] WORDS_PER_LINE = ADDR_W'(LINE_WIDTH / 4);

    state_t     state;
    logic [7:0] pack;
    logic [1:0] pix_mapped;
    logic       ovf_ev;
    logic       short_line_ev;
    logic       short_frame_ev;

`ifdef LCD_CAPTURE_PALETTE_EN
    always_comb begin
        pix_mapped = pal_raw[{pix_data, 1'b0} +: 2];
    end
`else
    logic unused_pal;
    assign unused_pal = ^pal_raw;

    always_comb begin
        pix_mapped = pix_data;
    end
`endif

    // frame_start outranks everything, so a pixel in the same cycle is neither stored nor flagged.
    always_comb begin
        ovf_ev         = !frame_start && pix_valid && (state != ACTIVE);
        short_line_ev  = (state == ACTIVE) && (cur_col != 8'd0) && (line_start || frame_start);
        short_frame_ev = frame_start && (state != IDLE);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pack            <= 8'd0;
            cur_line        <= 8'd0;
            cur_col         <= 8'd0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= 8'd0;
            frame_done      <= 1'b0;
            frame_count     <= 8'd0;
            err_overflow    <= 1'b0;
            err_short_line  <= 1'b0;
            err_short_frame <= 1'b0;
        end else begin
            mem_we          <= 1'b0;
            frame_done      <= 1'b0;
            err_overflow    <= (err_overflow    && !err_clear) || ovf_ev;
            err_short_line  <= (err_short_line  && !err_clear) || short_line_ev;
            err_short_frame <= (err_short_frame && !err_clear) || short_frame_ev;

            if (frame_start) begin
                cur_line <= 8'd0;
                cur_col  <= 8'd0;
                pack     <= 8'd0;
                state    <= line_start ? ACTIVE : WAIT_LINE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    WAIT_LINE: begin
                        if (line_start) begin
                            state   <= ACTIVE;
                            cur_col <= 8'd0;
                            pack    <= 8'd0;
                        end
                    end
                    ACTIVE: begin
                        if (line_start && cur_col != 8'd0) begin
                            // Truncated line: drop the partial byte and move to the next line.
                            pack    <= 8'd0;
                            cur_col <= 8'd0;
                            if (cur_line == LAST_LINE) begin
                                state    <= IDLE;
                                cur_line <= 8'd0;
                            end else begin
                                cur_line <= cur_line + 8'd1;
                            end
                        end else if (pix_valid) begin
                            pack <= {pack[5:0], pix_mapped};
                            if (cur_col[1:0] == 2'd3) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= ADDR_W'(cur_line) * WORDS_PER_LINE
                                             + ADDR_W'(cur_col[7:2]);
                                mem_wdata <= {pack[5:0], pix_mapped};
                            end
                            if (cur_col == LAST_COL) begin
                                cur_col <= 8'd0;
                                if (cur_line == LAST_LINE) begin
                                    state       <= IDLE;
                                    cur_line    <= 8'd0;
                                    frame_done  <= 1'b1;
                                    frame_count <= frame_count + 8'd1;
                                end else begin
                                    state    <= WAIT_LINE;
                                    cur_line <= cur_line + 8'd1;
                                end
                            end else begin
                                cur_col <= cur_col + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
